// File: rtl/unsigned_mul_8x8_ha_array_accum_pkg.sv
// Shared types and geometry for the half-adder-array product accumulator.
package unsigned_mul_8x8_ha_array_accum_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
  localparam int ROW_COUNT = 4;
  localparam int T_W       = 9;
  localparam int B_W       = 7;
  localparam int ROW_VAL_W = 10;
  localparam int ACC_W     = 17;
endpackage

// File: rtl/unsigned_mul_8x8_ha_array_accum_ha_row_value.sv
// Combinational row value: sum row plus carry row shifted into place.
module ha_row_value
  import unsigned_mul_8x8_ha_array_accum_pkg::*;
(
  input  logic [T_W-1:0]       t_i,
  input  logic [B_W-1:0]       b_i,
  output logic [ROW_VAL_W-1:0] v_o
);
  assign v_o = ROW_VAL_W'(t_i) + (ROW_VAL_W'(b_i) << 2);
endmodule

// File: rtl/unsigned_mul_8x8_ha_array_accum.sv
// Captures four half-adder rows and accumulates their weighted values,
// ROWS_PER_CYCLE rows per clock, then presents the 16-bit product with a handshake.
module unsigned_mul_8x8_ha_array_accum
  import unsigned_mul_8x8_ha_array_accum_pkg::*;
#(
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [B_W-1:0]   ha_array_0_b,
  input  logic [B_W-1:0]   ha_array_1_b,
  input  logic [B_W-1:0]   ha_array_2_b,
  input  logic [B_W-1:0]   ha_array_3_b,
  input  logic [T_W-1:0]   ha_array_0_t,
  input  logic [T_W-1:0]   ha_array_1_t,
  input  logic [T_W-1:0]   ha_array_2_t,
  input  logic [T_W-1:0]   ha_array_3_t,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      out_product,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 || ROWS_PER_CYCLE == 4)) begin : g_bad_rows
    $error("ROWS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d, acc_sum;
  logic [2:0]            idx_q, idx_d;
  logic                  out_valid_q, out_valid_d;
  logic                  load;
  logic [T_W-1:0]        t_q [ROW_COUNT];
  logic [B_W-1:0]        b_q [ROW_COUNT];
  logic [T_W-1:0]        t_in [ROW_COUNT];
  logic [B_W-1:0]        b_in [ROW_COUNT];
  logic [1:0]            row_sel [ROWS_PER_CYCLE];
  logic [ROW_VAL_W-1:0]  row_val [ROWS_PER_CYCLE];
  logic                  last_step;

  assign t_in[0] = ha_array_0_t;
  assign t_in[1] = ha_array_1_t;
  assign t_in[2] = ha_array_2_t;
  assign t_in[3] = ha_array_3_t;
  assign b_in[0] = ha_array_0_b;
  assign b_in[1] = ha_array_1_b;
  assign b_in[2] = ha_array_2_b;
  assign b_in[3] = ha_array_3_b;

  for (genvar j = 0; j < ROWS_PER_CYCLE; j++) begin : g_row
    assign row_sel[j] = idx_q[1:0] + 2'(j);
    ha_row_value u_row (
      .t_i (t_q[row_sel[j]]),
      .b_i (b_q[row_sel[j]]),
      .v_o (row_val[j])
    );
  end

  // Row i carries weight 4^i; the 17-bit sum never wraps (max 86615).
  always_comb begin
    acc_sum = acc_q;
    for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
      acc_sum = acc_sum + (ACC_W'(row_val[j]) << {row_sel[j], 1'b0});
    end
  end

  assign last_step = (idx_q + 3'(ROWS_PER_CYCLE)) == 3'(ROW_COUNT);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_valid_d = 1'b0;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ACCUM;
          acc_d   = '0;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      ACCUM: begin
        acc_d = acc_sum;
        idx_d = idx_q + 3'(ROWS_PER_CYCLE);
        if (last_step) state_d = DONE;
      end
      DONE: begin
        // Result is presented one cycle after entering DONE.
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < ROW_COUNT; i++) begin
        t_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      if (load) begin
        for (int i = 0; i < ROW_COUNT; i++) begin
          t_q[i] <= t_in[i];
          b_q[i] <= b_in[i];
        end
      end
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = out_valid_q;
  assign out_product = acc_q[15:0];
  assign out_ovf     = acc_q[16];
endmodule

// File: doc/unsigned_mul_8x8_ha_array_accum.md
UNSIGNED_MUL_8X8_HA_ARRAY_ACCUM -- requirements
Module: unsigned_mul_8x8_ha_array_accum

Interface
REQ-001 SHALL have parameter ROWS_PER_CYCLE, default 1: rows summed per accumulate cycle; legal values 1, 2, 4; any other value is an elaboration error.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have ports ha_array_0_b .. ha_array_3_b, input, 7 bits each: half-adder carry row i, where bit k has weight 2^(2i+k+2).
REQ-005 SHALL have ports ha_array_0_t .. ha_array_3_t, input, 9 bits each: sum row i, where bit k has weight 2^(2i+k).
REQ-006 SHALL have port in_valid, input, 1 bit: all eight row buses are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept rows.
REQ-008 SHALL have port out_product, output, 16 bits: accumulated product, modulo 2^16.
REQ-009 SHALL have port out_ovf, output, 1 bit: true sum was at least 2^16.
REQ-010 SHALL have port out_valid, output, 1 bit: out_product and out_ovf are valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port busy, output, 1 bit: state is not IDLE.

Function
REQ-013 SHALL define row value Vi = ti + (bi << 2), 10 bits wide, and product = sum over i of (Vi << 2i).
REQ-014 SHALL implement states IDLE, ACCUM and DONE.
REQ-015 SHALL assert in_ready only in IDLE.
REQ-016 SHALL, on in_valid && in_ready, register all 8 buses, clear the 17-bit accumulator and row index, and enter ACCUM.
REQ-017 SHALL, in each ACCUM cycle, add ROWS_PER_CYCLE consecutive row terms, starting at row 0, and advance the row index by ROWS_PER_CYCLE.
REQ-018 SHALL leave ACCUM for DONE on the cycle that adds row 3; the number of ACCUM cycles is 4/ROWS_PER_CYCLE.
REQ-019 SHALL assert out_valid in DONE only; out_valid rises exactly 1 + 4/ROWS_PER_CYCLE cycles after the accepting edge.
REQ-020 SHALL drive out_product = accumulator[15:0] and out_ovf = accumulator[16], and SHALL hold both, with out_valid, stable while out_valid && !out_ready.
REQ-021 SHALL, on out_valid && out_ready, return to IDLE; in_ready rises the next cycle, so there is no same-cycle accept-and-complete.
REQ-022 SHALL ignore input buses outside the accepting cycle; input changes during ACCUM or DONE SHALL NOT affect the result.
REQ-023 SHALL keep the 17-bit accumulator from wrapping: the maximum sum 1019 × 85 = 86615 fits in 17 bits.

Reset
REQ-024 SHALL, with rst_n low at a clock edge, enter IDLE and set in_ready=1 (the IDLE value), out_valid=0, busy=0, out_product=0, out_ovf=0, and clear the captured rows and row index.
REQ-025 SHALL, if reset is applied during ACCUM or DONE, discard the in-flight result; out_valid is 0 on the cycle after the reset edge.

Structure
REQ-026 SHALL place in a shared package: the state enum, ROW_COUNT=4, T_W=9, B_W=7, ROW_VAL_W=10 and ACC_W=17.
REQ-027 SHALL instantiate sub-module ha_row_value (combinational, Vi = t + (b << 2)), once per row summed per cycle.

Verification
REQ-028 SHALL verify, with R=1, only ha_array_0_t=9'h001 and in_valid for 1 cycle: out_valid after 5 cycles, out_product=16'd1, out_ovf=0.
REQ-029 SHALL verify, with R=1, only ha_array_2_b=7'h01: out_product=16'd64; with only ha_array_3_t=9'h001: out_product=16'd64.
REQ-030 SHALL verify, with R=1, 2 and 4, all t=9'h1FF and all b=7'h7F: out_product=16'd21079, out_ovf=1, with out_valid latency of 5, 3 and 2 cycles respectively.
REQ-031 SHALL verify out_ready held low for 10 cycles with inputs toggling randomly: out_product stays constant and in_ready stays 0; after one out_ready pulse, in_ready=1 on the next cycle.
REQ-032 SHALL verify rst_n pulsed low during the 2nd ACCUM cycle: no out_valid afterwards, in_ready=1 and busy=0 after the edge, and the next transaction produces the correct sum.
REQ-033 SHALL verify, against a golden model over 10^4 random vectors of x and y, that the output equals the model sum of the approximate rows for every ROWS_PER_CYCLE value.
